// File: rtl/timer_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_bank_pkg
// Description : Register map offsets and TCON bit positions shared by the
//               timer bank and its channels.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_bank_pkg;

   localparam logic [31:0] OFF_TH     = 32'h0000_0000;
   localparam logic [31:0] OFF_TL     = 32'h0000_0004;
   localparam logic [31:0] OFF_TCON   = 32'h0000_0008;
   localparam logic [31:0] OFF_PSC    = 32'h0000_000C;
   localparam logic [31:0] OFF_STATUS = 32'h0000_0100;
   localparam logic [31:0] OFF_PEND   = 32'h0000_0104;
   localparam logic [31:0] CH_STRIDE  = 32'h0000_0010;

   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_OS = 2;

endpackage
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
// Module      : timer_channel
// Description : One up-counting auto-reload timer (TH/TL/TCON, optional PSC
//               when TIMER_PRESCALER_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module timer_channel
   import timer_bank_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_wr_th,
   input  logic             i_wr_tl,
   input  logic             i_wr_tcon,
`ifdef TIMER_PRESCALER_EN
   input  logic             i_wr_psc,
   output logic [7:0]       o_psc,
`endif
   input  logic [CNT_W-1:0] i_wdata,
   output logic [CNT_W-1:0] o_th,
   output logic [CNT_W-1:0] o_tl,
   output logic [2:0]       o_tcon,
   output logic             o_ovf
);

   logic [CNT_W-1:0] r_th;
   logic [CNT_W-1:0] r_tl;
   logic [2:0]       r_tcon;
   logic             w_tick;

`ifdef TIMER_PRESCALER_EN
   logic [7:0] r_psc;
   logic [7:0] r_pcnt;

   assign w_tick = r_tcon[TCON_EN] && (r_pcnt == r_psc);
   assign o_psc  = r_psc;

   // Any PSC/TCON write restarts the interval so the new setting applies cleanly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_psc  <= '0;
         r_pcnt <= '0;
      end else begin
         if (i_wr_psc)
            r_psc <= i_wdata[7:0];
         if (i_wr_psc || i_wr_tcon || !r_tcon[TCON_EN] || w_tick)
            r_pcnt <= '0;
         else
            r_pcnt <= r_pcnt + 8'd1;
      end
   end
`else
   assign w_tick = r_tcon[TCON_EN];
`endif

   assign o_ovf = w_tick && (&r_tl);

   // Bus writes take priority over the tick; reload reads TH before any same-cycle write lands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_th   <= '0;
         r_tl   <= '0;
         r_tcon <= '0;
      end else begin
         if (i_wr_th)
            r_th <= i_wdata;

         if (i_wr_tl)
            r_tl <= i_wdata;
         else if (o_ovf)
            r_tl <= r_th;
         else if (w_tick)
            r_tl <= r_tl + CNT_W'(1);

         if (i_wr_tcon)
            r_tcon <= i_wdata[2:0];
         else if (o_ovf && r_tcon[TCON_OS])
            r_tcon[TCON_EN] <= 1'b0;
      end
   end

   assign o_th   = r_th;
   assign o_tl   = r_tl;
   assign o_tcon = r_tcon;

endmodule
`default_nettype wire

// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : timer_bank
// Description : Bus-mapped bank of auto-reload timers with W1C overflow
//               status and one aggregated interrupt. TIMER_PRESCALER_EN adds
//               a per-channel 8-bit prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_bank
   import timer_bank_pkg::*;
#(
   parameter int          NUM_TIMERS = 2,
   parameter int          CNT_W      = 32,
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irqout
);

   logic [31:0]           w_off;
   logic [3:0]            w_ch;
   logic [3:0]            w_reg;
   logic                  w_ch_hit;
   logic [NUM_TIMERS-1:0] w_ovf;
   logic [NUM_TIMERS-1:0] w_ie;
   logic [NUM_TIMERS-1:0] w_clr;
   logic [NUM_TIMERS-1:0] r_status;
   logic [CNT_W-1:0]      w_th   [NUM_TIMERS];
   logic [CNT_W-1:0]      w_tl   [NUM_TIMERS];
   logic [2:0]            w_tcon [NUM_TIMERS];
`ifdef TIMER_PRESCALER_EN
   logic [7:0]            w_psc  [NUM_TIMERS];
`endif

   assign w_off    = addr - BASE_ADDR;
   assign w_ch     = w_off[7:4];
   assign w_reg    = w_off[3:0];
   assign w_ch_hit = (w_off < (32'(NUM_TIMERS) * CH_STRIDE));

   for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_ch
      logic w_sel;
      assign w_sel = wr && w_ch_hit && (w_ch == 4'(k));

      timer_channel #(.CNT_W(CNT_W)) u_ch (
         .clk       (clk),
         .reset     (reset),
         .i_wr_th   (w_sel && (w_reg == OFF_TH[3:0])),
         .i_wr_tl   (w_sel && (w_reg == OFF_TL[3:0])),
         .i_wr_tcon (w_sel && (w_reg == OFF_TCON[3:0])),
`ifdef TIMER_PRESCALER_EN
         .i_wr_psc  (w_sel && (w_reg == OFF_PSC[3:0])),
         .o_psc     (w_psc[k]),
`endif
         .i_wdata   (wdata[CNT_W-1:0]),
         .o_th      (w_th[k]),
         .o_tl      (w_tl[k]),
         .o_tcon    (w_tcon[k]),
         .o_ovf     (w_ovf[k])
      );

      assign w_ie[k] = w_tcon[k][TCON_IE];
   end

   assign w_clr = (wr && (w_off == OFF_STATUS)) ? wdata[NUM_TIMERS-1:0] : '0;

   // A fresh overflow outranks a same-cycle clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_status <= '0;
      else
         r_status <= (r_status & ~w_clr) | w_ovf;
   end

   assign irqout = |(r_status & w_ie);

   always_comb begin
      rdata = '0;
      if (rd) begin
         if (w_off == OFF_STATUS)
            rdata = 32'(r_status);
         else if (w_off == OFF_PEND)
            rdata = 32'(r_status & w_ie);
         else if (w_ch_hit) begin
            for (int k = 0; k < NUM_TIMERS; k++) begin
               if (w_ch == 4'(k)) begin
                  case (w_reg)
                     OFF_TH[3:0]:   rdata = 32'(w_th[k]);
                     OFF_TL[3:0]:   rdata = 32'(w_tl[k]);
                     OFF_TCON[3:0]: rdata = 32'(w_tcon[k]);
`ifdef TIMER_PRESCALER_EN
                     OFF_PSC[3:0]:  rdata = 32'(w_psc[k]);
`endif
                     default:       rdata = '0;
                  endcase
               end
            end
         end
      end
   end

endmodule
`default_nettype wire
